// File: rtl/parity_mem_pkg.sv
// Shared constants and parity helper for the parity_mem memory block.
package parity_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int PAR_MAX_W  = 64;

    // Zero-extended inputs leave the XOR unchanged, so one width serves all.
    function automatic logic calc_parity(
        input logic [PAR_MAX_W-1:0] data,
        input logic                 odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_mem_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = parity_mem_pkg::CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/parity_mem.sv
// Single-port memory storing {parity, data} with checked registered reads,
// uninitialised-word tracking and saturating error counters.
module parity_mem
    import parity_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_inject,
    input  logic              clr_cnt,
    output logic [DATA_W:0]   data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              uninit,
    output logic              rw_err,
    output logic [CNT_W-1:0]  rw_err_cnt,
    output logic [CNT_W-1:0]  par_err_cnt
);

    localparam int   DEPTH   = 2 ** ADDR_W;
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    logic [DATA_W:0]    mem [DEPTH];
    logic [DEPTH-1:0]   wvalid;

    logic               wr_en;
    logic               rd_en;
    logic               conflict;
    logic [DATA_W:0]    rd_word;
    logic               rd_init;
    logic               rd_perr;
    logic               wr_par;
    logic [DATA_W:0]    zero_word;
    logic               par_inc;

    always_comb begin
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        conflict = 1'b0;
        unique case (1'b1)
            (write && read):  conflict = 1'b1;
            (write && !read): wr_en    = 1'b1;
            (read && !write): rd_en    = 1'b1;
            default: ;
        endcase
    end

    assign rd_word   = mem[address];
    assign rd_init   = wvalid[address];
    assign rd_perr   = rd_word[DATA_W] !=
                       calc_parity(PAR_MAX_W'(rd_word[DATA_W-1:0]), ODD_BIT);
    assign wr_par    = calc_parity(PAR_MAX_W'(data_in), ODD_BIT)
                       ^ parity_inject;
    assign zero_word = {calc_parity('0, ODD_BIT), {DATA_W{1'b0}}};
    assign par_inc   = rd_en && rd_init && rd_perr;

    // Storage is deliberately left unreset; only the valid bits clear.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[address] <= {wr_par, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wvalid <= '0;
        end else if (wr_en) begin
            wvalid[address] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            uninit     <= 1'b0;
            rw_err     <= 1'b0;
        end else begin
            data_valid <= rd_en;
            parity_err <= par_inc;
            uninit     <= rd_en && !rd_init;
            rw_err     <= conflict;
            if (rd_en) begin
                data_out <= rd_init ? rd_word : zero_word;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_rw_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (conflict),
        .clr   (clr_cnt),
        .cnt   (rw_err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_par_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (par_inc),
        .clr   (clr_cnt),
        .cnt   (par_err_cnt)
    );

endmodule

// File: tb/tb_parity_mem.sv
// Scoreboard bench for parity_mem: even/16-bit main instance plus a small
// odd-parity instance with 2-bit counters.
module tb_parity_mem;

    typedef struct packed {
        logic [8:0] dout;
        logic       perr;
        logic       uninit;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write;
    logic        read;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic        parity_inject;
    logic        clr_cnt;

    logic [8:0]  data_out;
    logic        data_valid;
    logic        parity_err;
    logic        uninit;
    logic        rw_err;
    logic [15:0] rw_err_cnt;
    logic [15:0] par_err_cnt;

    logic [8:0]  d1_data_out;
    logic        d1_data_valid;
    logic        d1_parity_err;
    logic        d1_uninit;
    logic        d1_rw_err;
    logic [1:0]  d1_rw_err_cnt;
    logic [1:0]  d1_par_err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0]  mem_m [int];
    bit          wv_m  [int];
    rd_exp_t     sb [$];
    logic        exp_valid = 1'b0;
    logic        exp_rw    = 1'b0;
    logic [15:0] rw_m      = '0;
    logic [15:0] par_m     = '0;
    bit          started   = 1'b0;

    always #5 clk = ~clk;

    parity_mem u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write         (write),
        .read          (read),
        .address       (address),
        .data_in       (data_in),
        .parity_inject (parity_inject),
        .clr_cnt       (clr_cnt),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_err    (parity_err),
        .uninit        (uninit),
        .rw_err        (rw_err),
        .rw_err_cnt    (rw_err_cnt),
        .par_err_cnt   (par_err_cnt)
    );

    parity_mem #(
        .DATA_W     (8),
        .ADDR_W     (4),
        .ODD_PARITY (1),
        .CNT_W      (2)
    ) u_dut_odd (
        .clk           (clk),
        .rst_n         (rst_n),
        .write         (write),
        .read          (read),
        .address       (address[3:0]),
        .data_in       (data_in),
        .parity_inject (parity_inject),
        .clr_cnt       (clr_cnt),
        .data_out      (d1_data_out),
        .data_valid    (d1_data_valid),
        .parity_err    (d1_parity_err),
        .uninit        (d1_uninit),
        .rw_err        (d1_rw_err),
        .rw_err_cnt    (d1_rw_err_cnt),
        .par_err_cnt   (d1_par_err_cnt)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Drives one edge's worth of inputs and advances the reference model.
    task automatic step(
        input logic        rn,
        input logic        w,
        input logic        r,
        input logic [15:0] a,
        input logic [7:0]  d,
        input logic        inj,
        input logic        clr
    );
        rd_exp_t e;
        logic [8:0] word;
        @(negedge clk);
        rst_n         = rn;
        write         = w;
        read          = r;
        address       = a;
        data_in       = d;
        parity_inject = inj;
        clr_cnt       = clr;
        @(posedge clk);
        if (!rn) begin
            exp_valid = 1'b0;
            exp_rw    = 1'b0;
            rw_m      = '0;
            par_m     = '0;
            wv_m.delete();
        end else begin
            exp_rw    = w && r;
            exp_valid = r && !w;
            if (w && r) rw_m = sat16(rw_m);
            if (w && !r) begin
                mem_m[int'(a)] = {(^d) ^ inj, d};
                wv_m[int'(a)]  = 1'b1;
            end
            if (r && !w) begin
                if (wv_m.exists(int'(a))) begin
                    word     = mem_m[int'(a)];
                    e.dout   = word;
                    e.perr   = (word[8] != (^word[7:0]));
                    e.uninit = 1'b0;
                    if (e.perr) par_m = sat16(par_m);
                end else begin
                    e.dout   = 9'h000;
                    e.perr   = 1'b0;
                    e.uninit = 1'b1;
                end
                sb.push_back(e);
            end
            if (clr) begin
                rw_m  = '0;
                par_m = '0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 16'h0, 8'h0, 0, 0);
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        if (started) begin
            check("valid", data_valid, exp_valid);
            check("rw_err", rw_err, exp_rw);
            check("rw_cnt", rw_err_cnt, rw_m);
            check("par_cnt", par_err_cnt, par_m);
            if (data_valid) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", data_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("dout", data_out, e.dout);
                    check("perr", parity_err, e.perr);
                    check("uninit", uninit, e.uninit);
                end
            end else begin
                check("flags_idle", {parity_err, uninit}, 2'b00);
            end
        end
    end

    logic [15:0] pool [5];

    initial begin
        pool[0] = 16'h0000;
        pool[1] = 16'h0010;
        pool[2] = 16'hFFFF;
        pool[3] = 16'h1234;
        pool[4] = 16'h8000;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 8'h0, 0, 0);
        started = 1'b1;
        check("rst_dout", data_out, 9'h000);
        check("rst_odd_cnt", d1_rw_err_cnt, 2'd0);

        step(1, 0, 1, 16'h1234, 8'h00, 0, 0);
        check("uninit_dout", data_out, 9'h000);
        check("odd_uninit_dout", d1_data_out, 9'h100);
        check("odd_uninit_flag", d1_uninit, 1'b1);

        step(1, 1, 0, 16'h0010, 8'hA5, 0, 0);
        step(1, 0, 1, 16'h0010, 8'h00, 0, 0);
        check("rd_a5", data_out, 9'h0A5);
        check("odd_rd_a5", d1_data_out, 9'h1A5);

        step(1, 1, 0, 16'hFFFF, 8'h01, 1, 0);
        step(1, 0, 1, 16'hFFFF, 8'h00, 0, 0);
        check("inj_dout", data_out, 9'h001);
        check("inj_perr", parity_err, 1'b1);
        check("inj_cnt", par_err_cnt, 16'd1);

        step(1, 1, 0, 16'h0000, 8'h03, 0, 0);
        step(1, 0, 1, 16'h0010, 8'h00, 0, 0);
        step(1, 0, 1, 16'hFFFF, 8'h00, 0, 0);
        step(1, 0, 1, 16'h0000, 8'h00, 0, 0);
        idle(2);
        check("hold", data_out, 9'h003);

        for (int i = 0; i < 3; i++) step(1, 1, 1, 16'h0010, 8'h3C, 0, 0);
        check("rw_cnt3", rw_err_cnt, 16'd3);
        step(1, 0, 1, 16'h0010, 8'h00, 0, 0);
        check("conflict_nowrite", data_out, 9'h0A5);

        step(1, 1, 1, 16'h0010, 8'h00, 0, 1);
        check("clr_rw_err", rw_err, 1'b1);
        check("clr_cnt0", rw_err_cnt, 16'd0);
        check("clr_odd_cnt0", d1_rw_err_cnt, 2'd0);

        for (int i = 0; i < 5; i++) step(1, 1, 1, 16'h0020, 8'h00, 0, 0);
        check("rw_cnt5", rw_err_cnt, 16'd5);
        check("odd_sat", d1_rw_err_cnt, 2'd3);
        idle(1);

        step(0, 0, 1, 16'h0010, 8'h00, 0, 0);
        check("rst_read_drop", data_valid, 1'b0);
        step(1, 0, 1, 16'h0010, 8'h00, 0, 0);
        check("post_rst_uninit", uninit, 1'b1);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 5));
            step(1, op <= 2 || op == 5, op >= 3,
                 pool[$urandom_range(0, 4)], 8'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end
        idle(3);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
